// File: rtl/freq_display_ctrl.sv
`default_nettype none
// ============================================================================
//  freq_display_ctrl
//  K*SCALE to BCD by double-dabble, shown on a multiplexed 7-segment display.
//  Revision: 1.0
// ============================================================================
module freq_display_ctrl #(
   parameter int K_W         = 24,
   parameter int SCALE       = 6,
   parameter int NUM_DIG     = 8,
   parameter int SCAN_DIV    = 50000,
   parameter bit SEG_ACT_LOW = 1'b0,
   parameter bit DIG_ACT_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [K_W-1:0]     K,
   output logic [6:0]         SEG,
   output logic [NUM_DIG-1:0] DIG,
   output logic               busy,
   output logic               ovf
);

   localparam int PROD_W  = K_W + 8;
   localparam int BCD_W   = NUM_DIG * 4;
   localparam int ITER_W  = $clog2(PROD_W + 1);
   localparam int PRESC_W = $clog2(SCAN_DIV);
   localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] CONV = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [6:0]         SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIG-1:0] DIG_OFF = DIG_ACT_LOW ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};

   logic [1:0]         state_q, state_d;
   logic [K_W-1:0]     k_last_q, k_last_d;
   logic               pending_q, pending_d;
   logic [PROD_W-1:0]  shift_q, shift_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               ovf_acc_q, ovf_acc_d;
   logic [ITER_W-1:0]  iter_q, iter_d;
   logic [BCD_W-1:0]   disp_q, disp_d;
   logic               ovf_q, ovf_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [IDX_W-1:0]   dig_idx_q, dig_idx_d;
   logic [6:0]         seg_q, seg_d;
   logic [NUM_DIG-1:0] dig_q, dig_d;

   logic [PROD_W-1:0]  product;
   logic [BCD_W-1:0]   bcd_adj;
   logic [NUM_DIG-1:0] blank;
   logic [3:0]         cur_nib;
   logic               cur_blank;
   logic [6:0]         seg_code;
   logic [NUM_DIG-1:0] dig_hot;

   assign product = {8'd0, K} * {{K_W{1'b0}}, 8'(SCALE)};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if ((K != k_last_q) || pending_q) state_d = LOAD;
         LOAD:    state_d = CONV;
         CONV:    if (iter_q == ITER_W'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state_q != IDLE);
   end

   // ---------------- conversion datapath ----------------
   always_comb begin
      bcd_adj = bcd_q;
      for (int n = 0; n < NUM_DIG; n++) begin
         if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
      end

      k_last_d  = k_last_q;
      pending_d = pending_q;
      shift_d   = shift_q;
      bcd_d     = bcd_q;
      ovf_acc_d = ovf_acc_q;
      iter_d    = iter_q;
      disp_d    = disp_q;
      ovf_d     = ovf_q;

      case (state_q)
         LOAD: begin
            k_last_d  = K;
            pending_d = 1'b0;
            shift_d   = product;
            bcd_d     = '0;
            ovf_acc_d = 1'b0;
            iter_d    = ITER_W'(PROD_W);
         end
         CONV: begin
            iter_d  = iter_q - ITER_W'(1);
            bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[PROD_W-1]};
            shift_d = {shift_q[PROD_W-2:0], 1'b0};
            // A carry out of the top digit means the value no longer fits
            if (bcd_adj[BCD_W-1]) ovf_acc_d = 1'b1;
         end
         DONE: begin
            disp_d = bcd_q;
            ovf_d  = ovf_acc_q;
         end
         default: ;
      endcase
   end

   // ---------------- scan and segment decode ----------------
   assign blank[0] = 1'b0;
   for (genvar n = 1; n < NUM_DIG; n++) begin : g_blank
      if (n == NUM_DIG - 1) begin : g_top
         assign blank[n] = (disp_q[n*4 +: 4] == 4'd0);
      end else begin : g_mid
         assign blank[n] = (disp_q[n*4 +: 4] == 4'd0) & blank[n+1];
      end
   end

   always_comb begin
      presc_d   = presc_q + PRESC_W'(1);
      dig_idx_d = dig_idx_q;
      if (presc_q == PRESC_W'(SCAN_DIV - 1)) begin
         presc_d   = '0;
         dig_idx_d = (dig_idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : dig_idx_q + IDX_W'(1);
      end

      cur_nib   = disp_q[3:0];
      cur_blank = 1'b0;
      for (int n = 0; n < NUM_DIG; n++) begin
         dig_hot[n] = (dig_idx_q == IDX_W'(n));
         if (dig_idx_q == IDX_W'(n)) begin
            cur_nib   = disp_q[n*4 +: 4];
            cur_blank = blank[n];
         end
      end

      case (cur_nib)
         4'd0:    seg_code = 7'h3F;
         4'd1:    seg_code = 7'h06;
         4'd2:    seg_code = 7'h5B;
         4'd3:    seg_code = 7'h4F;
         4'd4:    seg_code = 7'h66;
         4'd5:    seg_code = 7'h6D;
         4'd6:    seg_code = 7'h7D;
         4'd7:    seg_code = 7'h07;
         4'd8:    seg_code = 7'h7F;
         4'd9:    seg_code = 7'h6F;
         default: seg_code = 7'h00;
      endcase
      if (ovf_q)          seg_code = 7'h40;
      else if (cur_blank) seg_code = 7'h00;

      seg_d = SEG_ACT_LOW ? ~seg_code : seg_code;
      dig_d = DIG_ACT_LOW ? ~dig_hot : dig_hot;
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_last_q  <= '0;
         pending_q <= 1'b1;
         shift_q   <= '0;
         bcd_q     <= '0;
         ovf_acc_q <= 1'b0;
         iter_q    <= '0;
         disp_q    <= '0;
         ovf_q     <= 1'b0;
         presc_q   <= '0;
         dig_idx_q <= '0;
         seg_q     <= SEG_OFF;
         dig_q     <= DIG_OFF;
      end else begin
         k_last_q  <= k_last_d;
         pending_q <= pending_d;
         shift_q   <= shift_d;
         bcd_q     <= bcd_d;
         ovf_acc_q <= ovf_acc_d;
         iter_q    <= iter_d;
         disp_q    <= disp_d;
         ovf_q     <= ovf_d;
         presc_q   <= presc_d;
         dig_idx_q <= dig_idx_d;
         seg_q     <= seg_d;
         dig_q     <= dig_d;
      end
   end

   assign SEG = seg_q;
   assign DIG = dig_q;
   assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_display_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_freq_display_ctrl
//  Directed self-checking bench: 8 digits, SCAN_DIV=4, active-low digit enables.
//  Revision: 1.0
// ============================================================================
module tb_freq_display_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] K;
   logic [6:0]  SEG;
   logic [7:0]  DIG;
   logic        busy;
   logic        ovf;

   int n_chk  = 0;
   int n_fail = 0;
   int bad_dig;
   logic [7:0] seen [8];

   freq_display_ctrl #(
      .K_W(24), .SCALE(6), .NUM_DIG(8), .SCAN_DIV(4),
      .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .K    (K),
      .SEG  (SEG),
      .DIG  (DIG),
      .busy (busy),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Count busy samples until busy falls; optionally count SEG values other than "0"/blank
   task automatic wait_done(input bit watch, output int cycles, output int odd);
      cycles = 0;
      odd    = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (watch && SEG != 7'h00 && SEG != 7'h3F) odd++;
         if (busy) cycles++;
         else if (cycles > 0) break;
      end
   endtask

   task automatic capture(input int n);
      for (int d = 0; d < 8; d++) seen[d] = 8'hFF;
      bad_dig = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if ($countones(~DIG) != 1) bad_dig++;
         else for (int d = 0; d < 8; d++) if (!DIG[d]) seen[d] = {1'b0, SEG};
      end
   endtask

   task automatic check_disp(input string tag, input logic [7:0][6:0] e);
      capture(32);
      chk({tag, "_dig_onehot"}, bad_dig, 0);
      for (int d = 0; d < 8; d++) chk($sformatf("%s_d%0d", tag, d), seen[d], {1'b0, e[d]});
   endtask

   initial begin
      int cyc;
      int odd;
      int cnt;

      rst_n = 1'b0;
      K     = 24'd0;
      repeat (3) @(negedge clk);
      chk("rst_seg", SEG, 7'h00);
      chk("rst_dig", DIG, 8'hFF);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);

      // Reset release with K=0 still converts once
      rst_n = 1'b1;
      wait_done(1'b0, cyc, odd);
      chk("k0_busy_cycles", cyc, 34);
      chk("k0_ovf", ovf, 0);
      check_disp("k0", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F});

      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      chk("k0_stay_idle", cnt, 0);

      K = 24'd1;
      wait_done(1'b0, cyc, odd);
      chk("k1_latency", cyc, 34);
      chk("k1_ovf", ovf, 0);
      check_disp("k1", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h7D});

      K = 24'd1000000;
      wait_done(1'b0, cyc, odd);
      chk("k1m_latency", cyc, 34);
      chk("k1m_ovf", ovf, 0);
      check_disp("k1m", {7'h00, 7'h7D, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});

      K = 24'hFFFFFF;
      wait_done(1'b0, cyc, odd);
      chk("kmax_latency", cyc, 34);
      chk("kmax_ovf", ovf, 1);
      check_disp("kmax", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

      // Change K mid-conversion: first commit is "6", then "12" follows immediately
      K = 24'd1;
      repeat (12) @(negedge clk);
      K = 24'd2;
      wait_done(1'b0, cyc, odd);
      chk("chg_first_latency", cyc + 12, 34);
      chk("chg_first_ovf", ovf, 0);
      check_disp("chg_first", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h7D});
      wait_done(1'b0, cyc, odd);
      chk("chg_second_tail", cyc, 2);
      check_disp("chg_second", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h5B});

      // Asynchronous reset in the middle of converting K=5
      K = 24'd5;
      repeat (15) @(negedge clk);
      chk("rst_mid_busy_before", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_seg", SEG, 7'h00);
      chk("async_dig", DIG, 8'hFF);
      chk("async_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_done(1'b1, cyc, odd);
      chk("rst_mid_latency", cyc, 34);
      chk("rst_mid_no_stale", odd, 0);
      check_disp("rst_mid", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h4F, 7'h3F});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
